// File: rtl/code_lock_pkg.sv
// Shared state encoding and keypad codes for the code lock.
package code_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_SETPW   = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_CLR   = 4'hC;
    localparam logic [3:0] KEY_SET   = 4'hD;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/code_lock_press_detect.sv
// Rising-edge detector on the keypad key-valid level; one pulse per key press.
module press_detect (
    input  logic CLK,
    input  logic rst,
    input  logic EN,
    output logic press
);

    logic en_q;
    logic en_d;

    always_comb begin
        en_d = EN;
    end

    // History resets high so a key already held at reset release is not a press.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            en_q <= 1'b1;
        end else begin
            en_q <= en_d;
        end
    end

    assign press = EN & ~en_q;

endmodule

// File: rtl/code_lock.sv
// Keypad code lock: digit buffer, password compare, open/lockout timing.
//
// state   | meaning
// IDLE    | locked, buffer empty, waiting for first digit
// ENTRY   | collecting digits of a code attempt
// OPEN    | unlocked, inactivity timer running
// SETPW   | unlocked, collecting a new password, timer frozen
// LOCKOUT | alarm after too many wrong codes, all keys ignored
module code_lock
    import code_lock_pkg::*;
#(
    parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
    parameter int unsigned OPEN_CYCLES    = 50_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 150_000_000,
    parameter int unsigned MAX_ERR        = 3
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        EN,
    input  logic [3:0]  key_value,
    output logic        unlock,
    output logic        alarm,
    output logic [15:0] entry,
    output logic [2:0]  digit_cnt,
    output logic [1:0]  err_cnt,
    output logic [2:0]  state_view
);

    localparam int unsigned MAX_CYCLES = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TIMER_W = $clog2(MAX_CYCLES) + 1;
    localparam logic [TIMER_W-1:0] OPEN_LOAD    = TIMER_W'(OPEN_CYCLES);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

    state_t               state_q, state_d;
    logic [15:0]          entry_q, entry_d;
    logic [2:0]           dc_q, dc_d;
    logic [1:0]           err_q, err_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [15:0]          pw_q, pw_d;
    logic                 unlock_q, unlock_d;
    logic                 alarm_q, alarm_d;

    logic                 press;
    logic                 key_ev;
    logic                 key_digit;
    logic [15:0]          entry_push;
    logic [15:0]          entry_pop;
    logic [2:0]           err_inc;
    logic                 err_limit;

    press_detect u_press_detect (
        .CLK   (CLK),
        .rst   (rst),
        .EN    (EN),
        .press (press)
    );

    // E and F are unused codes and never count as key events.
    assign key_ev     = press && (key_value < 4'hE);
    assign key_digit  = is_digit(key_value);
    assign entry_push = {entry_q[11:0], key_value};
    assign entry_pop  = {4'h0, entry_q[15:4]};
    assign err_inc    = {1'b0, err_q} + 3'd1;
    assign err_limit  = (32'(err_inc) >= MAX_ERR);

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        dc_d    = dc_q;
        err_d   = err_q;
        timer_d = timer_q;
        pw_d    = pw_q;

        case (state_q)
            ST_IDLE: begin
                if (key_ev && key_digit) begin
                    entry_d = entry_push;
                    dc_d    = dc_q + 3'd1;
                    state_d = ST_ENTRY;
                end
            end

            ST_ENTRY: begin
                if (key_ev) begin
                    if (key_digit) begin
                        if (dc_q < 3'd4) begin
                            entry_d = entry_push;
                            dc_d    = dc_q + 3'd1;
                        end
                    end else if (key_value == KEY_BACK) begin
                        if (dc_q <= 3'd1) begin
                            entry_d = 16'h0;
                            dc_d    = 3'd0;
                            state_d = ST_IDLE;
                        end else begin
                            entry_d = entry_pop;
                            dc_d    = dc_q - 3'd1;
                        end
                    end else if (key_value == KEY_CLR) begin
                        entry_d = 16'h0;
                        dc_d    = 3'd0;
                        state_d = ST_IDLE;
                    end else if (key_value == KEY_ENTER) begin
                        entry_d = 16'h0;
                        dc_d    = 3'd0;
                        if (dc_q == 3'd4 && entry_q == pw_q) begin
                            err_d   = 2'd0;
                            timer_d = OPEN_LOAD;
                            state_d = ST_OPEN;
                        end else begin
                            err_d = err_inc[1:0];
                            if (err_limit) begin
                                timer_d = LOCKOUT_LOAD;
                                state_d = ST_LOCKOUT;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
            end

            // Keys take priority over a timer expiring in the same cycle.
            ST_OPEN: begin
                if (key_ev && key_value == KEY_CLR) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else if (key_ev && key_value == KEY_SET) begin
                    state_d = ST_SETPW;
                end else if (timer_q <= TIMER_ONE) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end

            ST_SETPW: begin
                if (key_ev) begin
                    if (key_digit) begin
                        if (dc_q < 3'd4) begin
                            entry_d = entry_push;
                            dc_d    = dc_q + 3'd1;
                        end
                    end else if (key_value == KEY_BACK) begin
                        if (dc_q != 3'd0) begin
                            entry_d = entry_pop;
                            dc_d    = dc_q - 3'd1;
                        end
                    end else if (key_value == KEY_ENTER) begin
                        if (dc_q == 3'd4) begin
                            pw_d    = entry_q;
                            entry_d = 16'h0;
                            dc_d    = 3'd0;
                            timer_d = '0;
                            state_d = ST_IDLE;
                        end
                    end else if (key_value == KEY_CLR) begin
                        entry_d = 16'h0;
                        dc_d    = 3'd0;
                        timer_d = '0;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_LOCKOUT: begin
                if (timer_q <= TIMER_ONE) begin
                    timer_d = '0;
                    err_d   = 2'd0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end

            default: begin
                entry_d = 16'h0;
                dc_d    = 3'd0;
                timer_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Indications follow the next state so they are registered and mutually exclusive.
        unlock_d = (state_d == ST_OPEN) || (state_d == ST_SETPW);
        alarm_d  = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            entry_q  <= 16'h0;
            dc_q     <= 3'd0;
            err_q    <= 2'd0;
            timer_q  <= '0;
            pw_q     <= DEFAULT_CODE;
            unlock_q <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            dc_q     <= dc_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
            pw_q     <= pw_d;
            unlock_q <= unlock_d;
            alarm_q  <= alarm_d;
        end
    end

    assign unlock     = unlock_q;
    assign alarm      = alarm_q;
    assign entry      = entry_q;
    assign digit_cnt  = dc_q;
    assign err_cnt    = err_q;
    assign state_view = state_q;

endmodule
